// File: rtl/kpn_pkg.sv
// rtl/kpn_pkg.sv - shared constants and types for the KPN channel and delay stages
//
// Contents:
//   KPN_DATA_WIDTH  word width used by every KPN stage
//   KPN_FIFO_DEPTH  default channel depth (slots)
//   KPN_IDLE_WORD   value presented by a stage with nothing to offer
//   kpn_op_e        per-cycle channel operation {write accepted, read accepted}
package kpn_pkg;

    localparam int KPN_DATA_WIDTH = 16;
    localparam int KPN_FIFO_DEPTH = 8;

    localparam logic [KPN_DATA_WIDTH-1:0] KPN_IDLE_WORD = 16'h0000;

    // Encoding is {wr_acc, rd_acc} so the enum can be cast from the strobe pair.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } kpn_op_e;

endpackage

// File: rtl/kpn_fifo_mem.sv
// rtl/kpn_fifo_mem.sv - simple dual-port storage array for the KPN channel
//
// Synchronous write, asynchronous read. Contents are not reset.
// Ports:
//   clk      in   write clock
//   wr_en    in   write enable
//   wr_addr  in   ADDR_WIDTH  write slot
//   wr_data  in   DATA_WIDTH  write word
//   rd_addr  in   ADDR_WIDTH  read slot
//   rd_data  out  DATA_WIDTH  word at rd_addr (combinational)
module kpn_fifo_mem
    import kpn_pkg::*;
#(
    parameter int DATA_WIDTH = KPN_DATA_WIDTH,
    parameter int DEPTH      = KPN_FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/kpn_fifo_channel.sv
// rtl/kpn_fifo_channel.sv - bounded first-word-fall-through FIFO for one KPN channel
//
// Optional statistics are built when KPN_FIFO_STATS_EN is defined.
// Ports:
//   clk           in   single clock, posedge
//   rst_n         in   asynchronous active-low reset
//   wr            in   producer write strobe
//   entry_1       in   DATA_WIDTH  producer word
//   rd            in   consumer pop strobe
//   output_1      out  DATA_WIDTH  head word, idle word when empty
//   full          out  channel holds DEPTH words
//   empty         out  channel holds no words
//   count         out  ADDR_WIDTH+1  occupancy 0..DEPTH
//   overflow      out  sticky, a write was rejected
//   underflow     out  sticky, a read was issued while empty
//   peak_count    out  ADDR_WIDTH+1  highest occupancy since reset (stats build)
//   stall_cycles  out  16  saturating count of rejected-write cycles (stats build)
module kpn_fifo_channel
    import kpn_pkg::*;
#(
    parameter int DATA_WIDTH = KPN_DATA_WIDTH,
    parameter int DEPTH      = KPN_FIFO_DEPTH,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] entry_1,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] output_1,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
`ifdef KPN_FIFO_STATS_EN
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   peak_count,
    output logic [15:0]           stall_cycles
`else
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO   = '0;
    localparam logic [ADDR_WIDTH:0]   CNT_FULL   = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic [DATA_WIDTH-1:0] head_word;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  wr_reject;
    kpn_op_e               op;

    // Flags decode only from the count register, so they never depend on wr/rd.
    assign full  = (count == CNT_FULL);
    assign empty = (count == CNT_ZERO);

    // A pop in the same cycle frees the slot a write into a full channel needs.
    assign rd_acc    = rd & ~empty;
    assign wr_acc    = wr & (~full | rd_acc);
    assign wr_reject = wr & full & ~rd_acc;

    assign op = kpn_op_e'({wr_acc, rd_acc});

    always_comb begin
        count_next = count;
        case (op)
            OP_WR:   count_next = count + CNT_ONE;
            OP_RD:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_next;
            if (wr_reject) begin
                overflow <= 1'b1;
            end
            if (rd & empty) begin
                underflow <= 1'b1;
            end
        end
    end

    kpn_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (entry_1),
        .rd_addr (rd_ptr),
        .rd_data (head_word)
    );

    // Stale storage is masked so a starved consumer sees the same idle word
    // the downstream delay stage holds before it fills.
    assign output_1 = empty ? DATA_WIDTH'(KPN_IDLE_WORD) : head_word;

`ifdef KPN_FIFO_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_count   <= '0;
            stall_cycles <= '0;
        end else begin
            if (count > peak_count) begin
                peak_count <= count;
            end
            if (wr_reject && (stall_cycles != 16'hffff)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// tb/tb_kpn_fifo_channel.sv - self-checking scoreboard bench for kpn_fifo_channel
module tb_kpn_fifo_channel;

    logic        clk;
    logic        rst_n;
    logic        wr;
    logic [15:0] entry_1;
    logic        rd;
    logic [15:0] output_1;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;
`ifdef KPN_FIFO_STATS_EN
    logic [3:0]  peak_count;
    logic [15:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [15:0] sb_q[$];
    logic        m_ovf;
    logic        m_unf;

    kpn_fifo_channel #(
        .DATA_WIDTH (16),
        .DEPTH      (8),
        .ADDR_WIDTH (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr           (wr),
        .entry_1      (entry_1),
        .rd           (rd),
        .output_1     (output_1),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
`ifdef KPN_FIFO_STATS_EN
        .underflow    (underflow),
        .peak_count   (peak_count),
        .stall_cycles (stall_cycles)
`else
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    // Synchronous reset pulse; leaves model and DUT both empty.
    task automatic apply_reset();
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; entry_1 = 16'h0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // One clock of stimulus. Expected words are pushed when the model accepts
    // a write and popped (and compared to the head) when it accepts a read.
    task automatic do_op(input logic w, input logic [15:0] d, input logic r);
        logic        m_rd_acc;
        logic        m_wr_acc;
        logic        m_full;
        logic [15:0] exp;
        @(negedge clk);
        wr = w; entry_1 = d; rd = r;
        m_full   = (sb_q.size() == 8);
        m_rd_acc = r && (sb_q.size() != 0);
        m_wr_acc = w && (!m_full || m_rd_acc);
        if (w && m_full && !m_rd_acc) m_ovf = 1'b1;
        if (r && sb_q.size() == 0)   m_unf = 1'b1;
        if (m_rd_acc) begin
            exp = sb_q.pop_front();
            n_checks++;
            if (output_1 !== exp)
                $display("FAIL pop_head: output_1=%h expected %h", output_1, exp);
            else
                n_pass++;
        end
        if (m_wr_acc) sb_q.push_back(d);
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr = 1'b0; rd = 1'b0; entry_1 = 16'h0;
        #1;
        n_checks++;
        if ({empty, full, count, output_1, overflow, underflow} !== {1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0})
            $display("FAIL reset_state: e=%b f=%b c=%0d o=%h ov=%b un=%b expected e=1 f=0 c=0 o=0 ov=0 un=0",
                     empty, full, count, output_1, overflow, underflow);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({empty, full, count, output_1} !== {1'b1, 1'b0, 4'd0, 16'h0})
            $display("FAIL idle_state: e=%b f=%b c=%0d o=%h expected e=1 f=0 c=0 o=0",
                     empty, full, count, output_1);
        else
            n_pass++;
    endtask

    task automatic test_fill_drain();
        apply_reset();
        for (int i = 1; i <= 8; i++) do_op(1'b1, 16'(i), 1'b0);
        @(negedge clk);
        n_checks++;
        if ({full, count, output_1} !== {1'b1, 4'd8, 16'h0001})
            $display("FAIL fill_full: f=%b c=%0d o=%h expected f=1 c=8 o=0001", full, count, output_1);
        else
            n_pass++;
        for (int i = 0; i < 8; i++) do_op(1'b0, 16'h0, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({empty, count, output_1} !== {1'b1, 4'd0, 16'h0})
            $display("FAIL drain_empty: e=%b c=%0d o=%h expected e=1 c=0 o=0", empty, count, output_1);
        else
            n_pass++;
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 1; i <= 8; i++) do_op(1'b1, 16'(i), 1'b0);
        do_op(1'b1, 16'hAAAA, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({overflow, count} !== {m_ovf, 4'(sb_q.size())})
            $display("FAIL overflow: ov=%b c=%0d expected ov=%b c=%0d", overflow, count, m_ovf, sb_q.size());
        else
            n_pass++;
        for (int i = 0; i < 8; i++) do_op(1'b0, 16'h0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (empty !== 1'b1)
            $display("FAIL overflow_drain: empty=%b expected 1", empty);
        else
            n_pass++;
    endtask

    task automatic test_full_simul();
        apply_reset();
        for (int i = 1; i <= 8; i++) do_op(1'b1, 16'(i), 1'b0);
        do_op(1'b1, 16'hBEEF, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({count, output_1, overflow} !== {4'd8, 16'h0002, 1'b0})
            $display("FAIL full_simul: c=%0d o=%h ov=%b expected c=8 o=0002 ov=0", count, output_1, overflow);
        else
            n_pass++;
        for (int i = 0; i < 8; i++) do_op(1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_empty_simul();
        apply_reset();
        do_op(1'b1, 16'h1234, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({underflow, count, output_1} !== {m_unf, 4'd1, 16'h1234})
            $display("FAIL empty_simul: un=%b c=%0d o=%h expected un=%b c=1 o=1234",
                     underflow, count, output_1, m_unf);
        else
            n_pass++;
        do_op(1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 3; i++) do_op(1'b1, 16'h5000 + 16'(i), 1'b0);
        for (int i = 0; i < 20; i++) do_op(1'b1, 16'h6000 + 16'($urandom_range(0, 4095)), 1'b1);
        @(negedge clk);
        n_checks++;
        if (count !== 4'd3)
            $display("FAIL wrap_count: count=%0d expected 3", count);
        else
            n_pass++;
        for (int i = 0; i < 3; i++) do_op(1'b0, 16'h0, 1'b1);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 5; i++) do_op(1'b1, 16'h7000 + 16'(i), 1'b0);
        @(negedge clk);
        n_checks++;
        if (count !== 4'd5)
            $display("FAIL mid_prefill: count=%0d expected 5", count);
        else
            n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({empty, full, count, output_1, overflow, underflow} !== {1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0})
            $display("FAIL async_reset: e=%b f=%b c=%0d o=%h ov=%b un=%b expected e=1 f=0 c=0 o=0 ov=0 un=0",
                     empty, full, count, output_1, overflow, underflow);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        do_op(1'b1, 16'h0055, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({output_1, count} !== {16'h0055, 4'd1})
            $display("FAIL post_reset_write: o=%h c=%0d expected o=0055 c=1", output_1, count);
        else
            n_pass++;
        do_op(1'b0, 16'h0, 1'b1);
    endtask

`ifdef KPN_FIFO_STATS_EN
    task automatic test_stats();
        apply_reset();
        for (int i = 0; i < 6; i++) do_op(1'b1, 16'h0100 + 16'(i), 1'b0);
        for (int i = 0; i < 6; i++) do_op(1'b0, 16'h0, 1'b1);
        @(negedge clk);
        n_checks++;
        if (peak_count !== 4'd6)
            $display("FAIL peak_count: peak=%0d expected 6", peak_count);
        else
            n_pass++;
        for (int i = 0; i < 8; i++) do_op(1'b1, 16'h0200 + 16'(i), 1'b0);
        for (int i = 0; i < 4; i++) do_op(1'b1, 16'hDEAD, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({stall_cycles, peak_count} !== {16'd4, 4'd8})
            $display("FAIL stall_cycles: stall=%0d peak=%0d expected stall=4 peak=8", stall_cycles, peak_count);
        else
            n_pass++;
        for (int i = 0; i < 8; i++) do_op(1'b0, 16'h0, 1'b1);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        wr = 1'b0; rd = 1'b0; entry_1 = 16'h0;
        sb_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_simul();
        test_empty_simul();
        test_wrap();
        test_reset_mid();
`ifdef KPN_FIFO_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
